// File: rtl/pic_ctl.sv
// pic_ctl: 8-line priority interrupt controller (8259 subset).
// Edge-latched requests, mask, in-service nesting, toggle handshake to CPU.
module pic_ctl #(
    parameter logic [15:0] BASE      = 16'h0020,
    parameter logic [7:0]  VEC_RESET = 8'h08
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        port_clk,
    input  logic [15:0] port,
    input  logic        port_w,
    input  logic [7:0]  port_o,
    output logic [7:0]  pic_dout,
    input  logic [7:0]  irq_in,
    output logic        intr,
    output logic [7:0]  irq,
    input  logic        intr_latch
);

    typedef enum logic {
        IDLE,
        WAIT_ACK
    } fsm_t;

    typedef enum logic {
        CMD,
        ICW2
    } cmd_t;

    fsm_t        state;
    cmd_t        cmd;
    logic [7:0]  irr;
    logic [7:0]  isr;
    logic [7:0]  imr;
    logic [7:0]  vbase;
    logic [7:0]  irq_prev;
    logic        sel_isr;

    logic        wr_cmd;
    logic        wr_data;
    logic        rd_cmd;
    logic        rd_data;
    logic        is_icw1;
    logic        is_ocw2;
    logic        is_ocw3;
    logic [7:0]  eoi_clr;
    logic        found;
    logic [2:0]  idx;
    logic        deliver;
    logic [7:0]  dlv_set;
    logic [7:0]  edges;
    logic [7:0]  irr_nxt;
    logic [7:0]  isr_nxt;

    assign wr_cmd  = port_clk & port_w & (port == BASE);
    assign wr_data = port_clk & port_w & (port == BASE + 16'd1);
    assign rd_cmd  = port_clk & ~port_w & (port == BASE);
    assign rd_data = port_clk & ~port_w & (port == BASE + 16'd1);

    always_comb begin
        is_icw1 = 1'b0;
        is_ocw2 = 1'b0;
        is_ocw3 = 1'b0;
        if (wr_cmd) begin
            unique case (1'b1)
                port_o[4]: is_icw1 = 1'b1;
                port_o[3]: is_ocw3 = 1'b1;
                default:   is_ocw2 = 1'b1;
            endcase
        end
    end

    // Non-specific EOI retires the highest-priority (lowest index) level.
    always_comb begin
        eoi_clr = 8'h00;
        if (is_ocw2) begin
            unique case (port_o[7:5])
                3'b001:  eoi_clr = isr & (~isr + 8'd1);
                3'b011:  eoi_clr = 8'd1 << port_o[2:0];
                default: eoi_clr = 8'h00;
            endcase
        end
    end

    // Level n is blocked by any in-service level at or above its priority.
    always_comb begin
        logic blk;
        blk   = 1'b0;
        found = 1'b0;
        idx   = 3'd0;
        for (int n = 0; n < 8; n++) begin
            blk = blk | isr[n];
            if (!found && irr[n] && !imr[n] && !blk) begin
                found = 1'b1;
                idx   = 3'(n);
            end
        end
    end

    assign deliver = (state == IDLE) & found;
    assign dlv_set = deliver ? (8'd1 << idx) : 8'h00;
    assign edges   = irq_in & ~irq_prev;
    assign irr_nxt = (irr & ~dlv_set) | edges;
    assign isr_nxt = (isr & ~eoi_clr) | dlv_set;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            cmd      <= CMD;
            irr      <= 8'h00;
            isr      <= 8'h00;
            imr      <= 8'h00;
            vbase    <= VEC_RESET;
            irq_prev <= 8'h00;
            sel_isr  <= 1'b0;
            pic_dout <= 8'h00;
            irq      <= 8'h00;
            intr     <= 1'b0;
        end else begin
            irq_prev <= irq_in;
            irr      <= irr_nxt;
            isr      <= isr_nxt;

            if (is_icw1) begin
                cmd <= ICW2;
            end

            if (wr_data) begin
                if (cmd == ICW2) begin
                    vbase <= port_o;
                    cmd   <= CMD;
                end else begin
                    imr <= port_o;
                end
            end

            if (is_ocw3) begin
                if (port_o[1:0] == 2'b10) begin
                    sel_isr <= 1'b0;
                end else if (port_o[1:0] == 2'b11) begin
                    sel_isr <= 1'b1;
                end
            end

            if (rd_cmd) begin
                pic_dout <= sel_isr ? isr : irr;
            end else if (rd_data) begin
                pic_dout <= imr;
            end

            case (state)
                IDLE: begin
                    if (found) begin
                        irq   <= vbase + {5'd0, idx};
                        intr  <= ~intr_latch;
                        state <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (intr == intr_latch) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pic_ctl.sv
// tb_pic_ctl: directed checks of pic_ctl delivery, nesting, EOI,
// mask, vector base programming and reset abandonment.
module tb_pic_ctl;

    localparam logic [15:0] BASE  = 16'h0020;
    localparam logic [15:0] BASE1 = 16'h0021;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        port_clk = 1'b0;
    logic [15:0] port = 16'h0000;
    logic        port_w = 1'b0;
    logic [7:0]  port_o = 8'h00;
    logic [7:0]  pic_dout;
    logic [7:0]  irq_in = 8'h00;
    logic        intr;
    logic [7:0]  irq;
    logic        intr_latch = 1'b0;

    int checks = 0;
    int errors = 0;

    pic_ctl #(
        .BASE(BASE),
        .VEC_RESET(8'h08)
    ) dut (
        .clock(clock),
        .reset(reset),
        .port_clk(port_clk),
        .port(port),
        .port_w(port_w),
        .port_o(port_o),
        .pic_dout(pic_dout),
        .irq_in(irq_in),
        .intr(intr),
        .irq(irq),
        .intr_latch(intr_latch)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        port_clk = 1'b1;
        port_w   = 1'b1;
        port     = a;
        port_o   = d;
        tick();
        port_clk = 1'b0;
        port_w   = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a);
        port_clk = 1'b1;
        port_w   = 1'b0;
        port     = a;
        tick();
        port_clk = 1'b0;
    endtask

    initial begin
        // reset state
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst_intr", {7'd0, intr}, 8'h00);
        chk("rst_irq", irq, 8'h00);
        chk("rst_dout", pic_dout, 8'h00);
        rd(BASE1);
        chk("rst_imr", pic_dout, 8'h00);

        // single request on IRQ0
        irq_in = 8'h01;
        tick();
        irq_in = 8'h00;
        chk("irq0_nolat", {7'd0, intr}, 8'h00);
        tick();
        chk("irq0_intr", {7'd0, intr}, 8'h01);
        chk("irq0_vec", irq, 8'h08);
        wr(BASE, 8'h0B);
        rd(BASE);
        chk("irq0_isr", pic_dout, 8'h01);
        intr_latch = 1'b1;
        tick();
        wr(BASE, 8'h20);
        rd(BASE);
        chk("irq0_eoi", pic_dout, 8'h00);

        // IRQ1 and IRQ3 together, IRQ3 waits for EOI
        irq_in = 8'h0A;
        tick();
        tick();
        chk("pri_vec", irq, 8'h09);
        chk("pri_intr", {7'd0, intr}, 8'h00);
        intr_latch = 1'b0;
        repeat (3) tick();
        chk("pri_hold", irq, 8'h09);
        chk("pri_noint", {7'd0, intr}, 8'h00);
        rd(BASE);
        chk("pri_isr", pic_dout, 8'h02);
        wr(BASE, 8'h0A);
        rd(BASE);
        chk("pri_irr", pic_dout, 8'h08);
        wr(BASE, 8'h20);
        tick();
        chk("pri_vec3", irq, 8'h0B);
        chk("pri_intr3", {7'd0, intr}, 8'h01);
        intr_latch = 1'b1;
        irq_in = 8'h00;
        tick();

        // nested IRQ1 while IRQ3 in service
        irq_in = 8'h02;
        tick();
        irq_in = 8'h00;
        tick();
        chk("nest_vec", irq, 8'h09);
        chk("nest_intr", {7'd0, intr}, 8'h00);
        wr(BASE, 8'h0B);
        rd(BASE);
        chk("nest_isr", pic_dout, 8'h0A);
        intr_latch = 1'b0;
        tick();
        wr(BASE, 8'h61);
        wr(BASE, 8'h63);
        rd(BASE);
        chk("spec_eoi", pic_dout, 8'h00);

        // vector base reprogramming
        wr(BASE, 8'h11);
        wr(BASE1, 8'h70);
        rd(BASE1);
        chk("icw_imr", pic_dout, 8'h00);
        irq_in = 8'h04;
        tick();
        irq_in = 8'h00;
        tick();
        chk("icw_vec", irq, 8'h72);
        chk("icw_intr", {7'd0, intr}, 8'h01);
        intr_latch = 1'b1;
        tick();
        wr(BASE, 8'h20);

        // mask holds request latched, unmask delivers
        wr(BASE, 8'h11);
        wr(BASE1, 8'h08);
        wr(BASE1, 8'h04);
        irq_in = 8'h04;
        tick();
        irq_in = 8'h00;
        repeat (3) tick();
        chk("mask_noint", {7'd0, intr}, 8'h01);
        wr(BASE, 8'h0A);
        rd(BASE);
        chk("mask_irr", pic_dout, 8'h04);
        wr(BASE1, 8'h00);
        tick();
        chk("unmask_vec", irq, 8'h0A);
        chk("unmask_intr", {7'd0, intr}, 8'h00);
        rd(BASE);
        chk("unmask_irr", pic_dout, 8'h00);
        intr_latch = 1'b0;
        tick();
        wr(BASE, 8'h20);

        // vector wraps at 8 bits
        wr(BASE, 8'h11);
        wr(BASE1, 8'hFC);
        irq_in = 8'h80;
        tick();
        irq_in = 8'h00;
        tick();
        chk("wrap_vec", irq, 8'h03);
        chk("wrap_intr", {7'd0, intr}, 8'h01);
        intr_latch = 1'b1;
        tick();
        wr(BASE, 8'h20);
        wr(BASE, 8'h11);
        wr(BASE1, 8'h08);

        // reset while waiting for ack
        irq_in = 8'h10;
        tick();
        irq_in = 8'h00;
        tick();
        chk("ab_vec", irq, 8'h0C);
        reset = 1'b1;
        intr_latch = 1'b0;
        tick();
        reset = 1'b0;
        chk("ab_intr", {7'd0, intr}, 8'h00);
        chk("ab_irq", irq, 8'h00);
        rd(BASE);
        chk("ab_irr", pic_dout, 8'h00);
        wr(BASE, 8'h0B);
        rd(BASE);
        chk("ab_isr", pic_dout, 8'h00);
        repeat (4) tick();
        chk("ab_quiet", {7'd0, intr}, 8'h00);
        chk("ab_quiet_irq", irq, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
